// File: rtl/bsn_result_serializer.sv
// Result serializer for the bitonic sorter network: captures one packed sorted
// vector and streams it out one element per beat with a first/last indication.
module bsn_result_serializer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_INPUTS   = 8,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_WIDTH*N_INPUTS-1:0]   data_in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [$clog2(N_INPUTS)-1:0]      out_index,
  output logic                             out_last,
  output logic                             busy
);

  localparam int unsigned IDX_W = $clog2(N_INPUTS);
  localparam int unsigned VEC_W = DATA_WIDTH * N_INPUTS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  state_t                 state_q, state_d;
  logic [VEC_W-1:0]       hold_q, hold_d;
  logic [DATA_WIDTH-1:0]  data_d;
  logic [IDX_W-1:0]       idx_d;
  logic                   valid_d, last_d, busy_d;
  logic                   beat_acc, capture;

  // Element k of a packed vector in the configured beat order.
  function automatic logic [DATA_WIDTH-1:0] pick(input logic [VEC_W-1:0] vec,
                                                 input logic [IDX_W-1:0] k);
    int unsigned pos;
    pos = MSB_FIRST ? (N_INPUTS - 1 - 32'(k)) : 32'(k);
    return vec[pos*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  // State and output registers; en=0 holds everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      out_data  <= '0;
      out_index <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else if (en) begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      out_data  <= data_d;
      out_index <= idx_d;
      out_valid <= valid_d;
      out_last  <= last_d;
      busy      <= busy_d;
    end
  end

  // Next-state and handshake logic; a final-beat accept may capture the next vector.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    data_d   = out_data;
    idx_d    = out_index;
    valid_d  = out_valid;
    last_d   = out_last;
    busy_d   = busy;
    in_ready = 1'b0;
    capture  = 1'b0;
    beat_acc = en & out_valid & out_ready;

    case (state_q)
      IDLE: begin
        in_ready = en;
        capture  = en & in_valid;
      end
      DRAIN: begin
        if (beat_acc) begin
          if (out_last) begin
            in_ready = 1'b1;
            if (in_valid) begin
              capture = 1'b1;
            end else begin
              state_d = IDLE;
              valid_d = 1'b0;
              last_d  = 1'b0;
              busy_d  = 1'b0;
            end
          end else begin
            idx_d  = out_index + IDX_W'(1);
            data_d = pick(hold_q, idx_d);
            last_d = (idx_d == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      state_d = DRAIN;
      hold_d  = data_in;
      idx_d   = '0;
      data_d  = pick(data_in, '0);
      valid_d = 1'b1;
      last_d  = (LAST_IDX == '0);
      busy_d  = 1'b1;
    end
  end

endmodule

// File: tb/tb_bsn_result_serializer.sv
// Scoreboard bench: one MSB-first and one LSB-first serializer share stimulus;
// expected beats are queued on each capture and popped by a negedge monitor.
module tb_bsn_result_serializer;

  localparam int DW = 32;
  localparam int N  = 8;
  localparam int IW = 3;

  typedef struct packed {
    logic [DW-1:0] d_msb;
    logic [DW-1:0] d_lsb;
    logic [IW-1:0] idx;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, en, in_valid, out_ready;
  logic [DW*N-1:0] data_in;
  logic          m_ir, m_ov, m_ol, m_busy;
  logic [DW-1:0] m_od;
  logic [IW-1:0] m_oi;
  logic          l_ir, l_ov, l_ol, l_busy;
  logic [DW-1:0] l_od;
  logic [IW-1:0] l_oi;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  logic          pend_hold = 1'b0, pend_next = 1'b0, pend_cap = 1'b0;
  logic [DW-1:0] prev_dm, prev_dl;
  logic [IW-1:0] prev_idx;
  logic          prev_last;

  always #5 clk = ~clk;

  bsn_result_serializer #(.DATA_WIDTH(DW), .N_INPUTS(N), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(m_ir),
    .data_in(data_in), .out_valid(m_ov), .out_ready(out_ready), .out_data(m_od),
    .out_index(m_oi), .out_last(m_ol), .busy(m_busy));

  bsn_result_serializer #(.DATA_WIDTH(DW), .N_INPUTS(N), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(l_ir),
    .data_in(data_in), .out_valid(l_ov), .out_ready(out_ready), .out_data(l_od),
    .out_index(l_oi), .out_last(l_ol), .busy(l_busy));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Packed vector whose first MSB-order element is base, then base+1, ...
  function automatic logic [DW*N-1:0] seq_vec(input int base);
    logic [DW*N-1:0] v;
    for (int j = 0; j < N; j++) v[DW*(N-1-j) +: DW] = DW'(base + j);
    return v;
  endfunction

  // Expected beat k: MSB-first takes word N-1-k counted from the bottom, LSB-first word k.
  task automatic push_vec(input logic [DW*N-1:0] vec);
    exp_t e;
    for (int k = 0; k < N; k++) begin
      e.d_msb = vec[DW*(N-1-k) +: DW];
      e.d_lsb = vec[DW*k +: DW];
      e.idx   = IW'(k);
      e.last  = (k == N - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic monitor_step();
    exp_t e;
    logic acc, cap, exp_ir;
    if (pend_hold) begin
      check("hold_valid", {m_ov, l_ov}, 2'b11);
      check("hold_data_msb", m_od, prev_dm);
      check("hold_data_lsb", l_od, prev_dl);
      check("hold_index", {m_oi, l_oi}, {prev_idx, prev_idx});
      check("hold_last", {m_ol, l_ol}, {prev_last, prev_last});
    end
    if (pend_next) check("no_bubble_valid", {m_ov, l_ov}, 2'b11);
    if (pend_cap)  check("first_beat_index", {m_oi, l_oi}, '0);
    exp_ir = m_ov ? (en & out_ready & m_ol) : en;
    check("in_ready", {m_ir, l_ir}, {exp_ir, exp_ir});
    check("busy", {m_busy, l_busy}, {m_ov, m_ov});
    if (!m_ov) check("last_idle", {m_ol, l_ol}, 2'b00);

    acc = en & m_ov & out_ready;
    cap = en & in_valid & m_ir;
    if (acc) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("beat_data_msb", m_od, e.d_msb);
        check("beat_data_lsb", l_od, e.d_lsb);
        check("beat_index", {m_oi, l_oi}, {e.idx, e.idx});
        check("beat_last", {m_ol, l_ol}, {e.last, e.last});
      end
    end
    if (cap) push_vec(data_in);

    pend_hold <= m_ov & !acc;
    pend_next <= acc & !m_ol;
    pend_cap  <= cap;
    prev_dm   <= m_od;
    prev_dl   <= l_od;
    prev_idx  <= m_oi;
    prev_last <= m_ol;
  endtask

  // Inputs change 1 ns after the rising edge, so mid-cycle sampling sees settled values.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      pend_hold <= 1'b0;
      pend_next <= 1'b0;
      pend_cap  <= 1'b0;
    end else begin
      monitor_step();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW*N-1:0] vec);
    data_in  = vec;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_index(input logic [IW-1:0] idx, input string name);
    bit found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m_ov && m_oi == idx) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check(name, found, 1'b1);
  endtask

  task automatic wait_drained(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!m_ov && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      step();
    end
    check(name, done, 1'b1);
  endtask

  initial begin
    rst       = 1'b0;
    en        = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    data_in   = seq_vec(100);
    repeat (3) step();
    check("rst_out_valid", {m_ov, l_ov}, 2'b00);
    check("rst_busy", {m_busy, l_busy}, 2'b00);
    check("rst_out_data", {m_od, l_od}, '0);
    check("rst_out_index", {m_oi, l_oi}, '0);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check("rst_release_in_ready", {m_ir, l_ir}, 2'b11);

    // Basic drain of {0..7}
    send(seq_vec(0));
    wait_drained("basic_drain_done");

    // Backpressure while element 2 is presented
    send(seq_vec(16));
    wait_index(3'd2, "bp_reach_idx2");
    out_ready = 1'b0;
    repeat (3) step();
    out_ready = 1'b1;
    wait_drained("bp_drain_done");

    // Back-to-back: second vector held valid until the final beat takes it
    send(seq_vec(0));
    data_in  = seq_vec(8);
    in_valid = 1'b1;
    wait_index(3'd7, "b2b_reach_last");
    step();
    in_valid = 1'b0;
    wait_drained("b2b_drain_done");

    // Enable freeze mid-drain
    send(seq_vec(0));
    wait_index(3'd3, "en_reach_idx3");
    en = 1'b0;
    repeat (2) step();
    en = 1'b1;
    wait_drained("en_drain_done");

    // Mid-drain reset at index 4
    send(seq_vec(40));
    wait_index(3'd4, "rst_reach_idx4");
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", {m_ov, l_ov}, 2'b00);
    check("mid_rst_busy", {m_busy, l_busy}, 2'b00);
    step();
    step();
    rst = 1'b1;
    send(seq_vec(56));
    wait_drained("post_rst_drain_done");

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      en        = ($urandom % 8) != 0;
      out_ready = ($urandom % 4) != 0;
      in_valid  = ($urandom % 3) == 0;
      for (int j = 0; j < N; j++) data_in[DW*j +: DW] = $urandom;
      step();
    end
    in_valid  = 1'b0;
    en        = 1'b1;
    out_ready = 1'b1;
    wait_drained("random_drain_done");
    step();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
